calculation_operand_loader: RTL and testbench

CALCULATION_OPERAND_LOADER -- requirements
Module: calculation_operand_loader

---
 rtl/calculation_operand_loader.sv | 136 +++++++++++++
 tb/tb_calculation_operand_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/calculation_operand_loader.sv
// Serial operand loader: assembles a framed four-word sequence into parallel
// operands a..d and holds them until the downstream stage consumes the set.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  LOAD_A | waiting for the start-of-frame word (operand a)
//  LOAD_B | a captured, waiting for operand b
//  LOAD_C | b captured, waiting for operand c
//  LOAD_D | c captured, waiting for operand d
//  HOLD   | full operand set presented, waiting for out_ready
module calculation_operand_loader #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW-1:0] in_data,
    input  logic          in_sof,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [BW-1:0] a,
    output logic [BW-1:0] b,
    output logic [BW-1:0] c,
    output logic [BW-1:0] d,
    output logic          div_zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   frame_cnt,
    output logic          sync_err
);

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        LOAD_D = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic [BW-1:0] c_q, c_d;
    logic [BW-1:0] d_q, d_d;
    logic          div_zero_q, div_zero_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          sync_err_q, sync_err_d;
    logic          beat;

    assign beat = in_valid && (state_q != HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            div_zero_q  <= 1'b0;
            frame_cnt_q <= 16'h0000;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            div_zero_q  <= div_zero_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        div_zero_d  = div_zero_q;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_err_q;

        case (state_q)
            LOAD_A: begin
                if (beat) begin
                    if (in_sof) begin
                        a_d     = in_data;
                        state_d = LOAD_B;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            LOAD_B, LOAD_C, LOAD_D: begin
                if (beat) begin
                    // A stray start-of-frame restarts assembly with this word as a.
                    if (in_sof) begin
                        a_d        = in_data;
                        sync_err_d = 1'b1;
                        state_d    = LOAD_B;
                    end else if (state_q == LOAD_B) begin
                        b_d        = in_data;
                        div_zero_d = (in_data == '0);
                        state_d    = LOAD_C;
                    end else if (state_q == LOAD_C) begin
                        c_d     = in_data;
                        state_d = LOAD_D;
                    end else begin
                        d_d     = in_data;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign d         = d_q;
    assign div_zero  = div_zero_q;
    assign frame_cnt = frame_cnt_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_calculation_operand_loader.sv
// Bench for calculation_operand_loader: directed framing scenarios plus random
// traffic, checked against a word-list model of frame assembly.
module tb_calculation_operand_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_sof = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a, b, c, d;
    logic        div_zero;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] frame_cnt;
    logic        sync_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: words gathered for the frame in progress, last value captured per
    // operand slot, whether a complete set is waiting, and the sticky flags.
    logic [7:0]  m_words[$];
    logic [7:0]  m_op[4];
    logic        m_dz;
    logic        m_hold;
    logic        m_err;
    logic [15:0] m_cnt;

    calculation_operand_loader #(.BW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .div_zero  (div_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_cnt (frame_cnt),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_hold});
        chk("a", {8'd0, a}, {8'd0, m_op[0]});
        chk("b", {8'd0, b}, {8'd0, m_op[1]});
        chk("c", {8'd0, c}, {8'd0, m_op[2]});
        chk("d", {8'd0, d}, {8'd0, m_op[3]});
        chk("div_zero", {15'd0, div_zero}, {15'd0, m_dz});
        chk("frame_cnt", frame_cnt, m_cnt);
        chk("sync_err", {15'd0, sync_err}, {15'd0, m_err});
    endtask

    task automatic model_clear();
        m_words.delete();
        for (int i = 0; i < 4; i++) m_op[i] = 8'h00;
        m_dz   = 1'b0;
        m_hold = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 16'h0000;
    endtask

    task automatic model_beat(input logic s, input logic [7:0] dat);
        if (s) begin
            if (m_words.size() != 0) m_err = 1'b1;
            m_words.delete();
            m_words.push_back(dat);
            m_op[0] = dat;
        end else if (m_words.size() == 0) begin
            m_err = 1'b1;
        end else begin
            m_words.push_back(dat);
            m_op[m_words.size() - 1] = dat;
            if (m_words.size() == 2) m_dz = (dat == 8'h00);
        end
        if (m_words.size() == 4) begin
            m_hold = 1'b1;
            m_words.delete();
        end
    endtask

    // One clock cycle: drive, check readiness, clock, advance model, check outputs.
    task automatic cyc(input logic v, input logic s, input logic [7:0] dat, input logic r);
        logic hold_before;
        in_valid  = v;
        in_sof    = s;
        in_data   = dat;
        out_ready = r;
        #1;
        chk("in_ready", {15'd0, in_ready}, {15'd0, !m_hold});
        hold_before = m_hold;
        @(posedge clk);
        if (v && !hold_before) model_beat(s, dat);
        if (hold_before && r) begin
            m_hold = 1'b0;
            m_cnt  = m_cnt + 16'd1;
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sof    = 1'b1;
        in_data   = 8'hAB;
        out_ready = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        rst = 1'b0;
        check_all();
    endtask

    task automatic frame(input logic [7:0] w0, w1, w2, w3);
        cyc(1'b1, 1'b1, w0, 1'b0);
        cyc(1'b1, 1'b0, w1, 1'b0);
        cyc(1'b1, 1'b0, w2, 1'b0);
        cyc(1'b1, 1'b0, w3, 1'b0);
    endtask

    initial begin
        model_clear();
        #1;
        do_reset();
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Basic frame, then handoff.
        frame(8'h0A, 8'h03, 8'h05, 8'h07);
        chk("s1_valid", {15'd0, out_valid}, 16'd1);
        chk("s1_a", {8'd0, a}, 16'h000A);
        chk("s1_d", {8'd0, d}, 16'h0007);
        chk("s1_dz", {15'd0, div_zero}, 16'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("s1_cnt", frame_cnt, 16'd1);
        chk("s1_ready", {15'd0, in_ready}, 16'd1);

        // Zero divisor, long stall with input activity.
        frame(8'h12, 8'h00, 8'h34, 8'h56);
        for (int i = 0; i < 10; i++)
            cyc(i[0], $urandom_range(0, 1) == 1, 8'($urandom), 1'b0);
        chk("s2_dz", {15'd0, div_zero}, 16'd1);
        chk("s2_b", {8'd0, b}, 16'h0000);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Resync on stray start-of-frame.
        do_reset();
        cyc(1'b1, 1'b1, 8'h11, 1'b0);
        cyc(1'b1, 1'b0, 8'h22, 1'b0);
        frame(8'h33, 8'h44, 8'h55, 8'h66);
        chk("s3_err", {15'd0, sync_err}, 16'd1);
        chk("s3_a", {8'd0, a}, 16'h0033);
        chk("s3_b", {8'd0, b}, 16'h0044);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Dropped word while waiting for a start-of-frame.
        do_reset();
        cyc(1'b1, 1'b0, 8'h99, 1'b0);
        chk("s4_err", {15'd0, sync_err}, 16'd1);
        chk("s4_a", {8'd0, a}, 16'h0000);
        frame(8'h01, 8'h02, 8'h03, 8'h04);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Frame counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        m_cnt = 16'hFFFF;
        frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("s5_wrap", frame_cnt, 16'h0000);

        // Reset in HOLD with a concurrent handoff.
        do_reset();
        frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        do_reset();
        chk("s6_valid", {15'd0, out_valid}, 16'd0);
        chk("s6_cnt", frame_cnt, 16'd0);
        chk("s6_a", {8'd0, a}, 16'h0000);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                $urandom_range(0, 2) != 0);

        // Back-to-back frames with out_ready high: one frame per five cycles.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            cyc(1'b1, 1'b1, 8'($urandom), 1'b1);
            cyc(1'b1, 1'b0, 8'($urandom), 1'b1);
            cyc(1'b1, 1'b0, 8'($urandom), 1'b1);
            cyc(1'b1, 1'b0, 8'($urandom), 1'b1);
            cyc(1'b1, 1'b1, 8'($urandom), 1'b1);
        end
        chk("s7_cnt", frame_cnt, 16'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
